iob_timer_sched: RTL
====================

# iob_timer_sched

Multi-channel alarm scheduler for the 64-bit free-running timer counter. Holds N_CH programmable 64-bit compare values, scans them round-robin against the live time count with a single shared 64-bit comparator, and raises per-channel pending flags and a combined interrupt. One-shot and periodic modes are supported. Sits beside the timer core and is accessed by the CPU over the native slave bus.

## Interface
- N_CH, 4: number of alarm channels; legal range 1..4.
- ADDR_W, 5: word address width; fixed by the register map.
- DATA_W, 32: bus data width.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- valid  in  1  CPU request.
- address  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  write strobes. Any nonzero value writes the full word; zero means read.
- rdata  out  DATA_W  read data, valid while ready=1.
- ready  out  1  request acknowledge.
- time_in  in  64  live timer count; assumed monotonic except when it is reset to 0.
- irq  out  1  `|(pending & ie)`, registered.

## Operation
- Per-channel register map, base 4n:
  - +0 CMP_LO.
  - +1 CMP_HI.
  - +2 PERIOD, 32-bit.
  - +3 CTRL: bit0 en, bit1 periodic, bit2 ie.
- Global registers:
  - 16 STATUS: pending[N_CH-1:0]; write-1-to-clear.
  - 17 TIME_LO: read returns time_in[31:0] and latches time_in[63:32] into a shadow register.
  - 18 TIME_HI: returns the shadow.
- Unmapped addresses, and channels at or above N_CH: reads return 0; writes are ignored.
- Arming:
  - A CTRL write with en=1 sets armed[n].
  - A CTRL write with en=0 clears armed[n].
  - CMP_LO, CMP_HI and PERIOD writes never change armed[n].
- Scanner: a pointer ptr cycles 0..N_CH-1, advancing one step per clk whenever out of reset.
- At ptr=n, if en[n] && armed[n] && time_in >= {CMP_HI,CMP_LO}[n] (unsigned), the channel fires:
  - pending[n] <= 1.
  - If periodic=1 and PERIOD!=0: cmp[n] <= cmp[n] + {32'b0,PERIOD}, 64-bit with wrap modulo 2^64. armed[n] stays 1.
  - Otherwise armed[n] <= 0 (one-shot). PERIOD=0 behaves as one-shot.
- The comparison is >=, not ==, so an alarm is never missed because of scan latency. A compare value already in the past fires on the first scan visit.
- A periodic channel that falls behind fires once per visit until it catches up. Each visit advances cmp by one PERIOD. pending stays set; no overflow counter is kept.
- Reset values: all registers 0, ptr=0, armed=0, pending=0, shadow=0, irq=0, ready=0, rdata=0.

## Timing
- Bus:
  - ready is asserted the cycle after valid, registered, for one cycle per valid cycle.
  - rdata is registered and valid in the same cycle as ready.
  - Writes take effect at the clk edge that samples valid.
- Alarm latency:
  - From the first cycle with time_in >= cmp to pending set: 1..N_CH cycles.
  - irq follows pending by 1 cycle.
- Simultaneous events:
  - CPU write to CMP or CTRL of channel n in the same cycle the scanner fires n: the CPU write wins for the written register. The scanner's pending set still takes effect.
  - STATUS W1C of bit n in the same cycle as a fire of n: the set wins and pending[n] stays 1.
  - Reading TIME_LO then TIME_HI gives a coherent 64-bit snapshot. Other accesses in between do not disturb the shadow.
- Reset asserted mid-operation clears all state asynchronously. ptr restarts at 0 on the first edge after deassertion.

## Test plan
- One-shot, N_CH=4:
  - Program ch1 CMP=100, CTRL=0b101; ramp time_in 0,1,2,...
  - Required: pending[1] sets 1..4 cycles after time_in reaches 100, irq one cycle later.
  - Required: no refire at 200; armed[1]=0.
- Periodic:
  - Program ch0 CMP=50, PERIOD=10, CTRL=0b111.
  - Required: fires near 50, 60 and 70; CMP_LO reads back 60 after the first fire.
  - W1C of STATUS between fires clears irq until the next fire.
- Late compare and 64-bit wrap:
  - time_in=1000 with CMP=5 and en set: fires on the first visit.
  - CMP=0xFFFF_FFFF_FFFF_FFF8 with PERIOD=16: after the fire, cmp reads 0x0000_0000_0000_0008.
- Collisions:
  - W1C of STATUS bit2 in the same cycle ch2 fires: pending[2] remains 1.
  - CTRL write en=0 in the same cycle ch3 fires: armed[3]=0 and pending[3]=1.
- Snapshot:
  - time_in=0x1_FFFF_FFFF; read TIME_LO, then time_in becomes 0x2_0000_0005, then read TIME_HI.
  - Required: 0xFFFF_FFFF and 0x1.
- Reset mid-run:
  - Assert rst low while ch0 is pending and irq=1.
  - Required: irq, pending, ready and rdata are 0 immediately, without a clock edge. All registers read 0 after release.

Source files
------------

// File: rtl/iob_timer_sched_if.sv
// Native slave bus bundle between the CPU and the alarm scheduler.
// A nonzero wstrb marks a write, and ready/rdata answer one cycle later.
interface iob_timer_sched_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, address, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/iob_timer_sched.sv
// Multi-channel alarm scheduler: round-robin scan of 64-bit compare values
// against the live timer with one shared comparator, one-shot/periodic modes.
module iob_timer_sched #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  iob_timer_sched_if.slave    bus,
  input  logic [63:0]         time_in,
  output logic                irq
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CH_W  = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] A_TIME_LO = ADDR_W'(17);
  localparam logic [ADDR_W-1:0] A_TIME_HI = ADDR_W'(18);

  logic [63:0]       cmp    [N_CH];
  logic [31:0]       period [N_CH];
  logic [N_CH-1:0]   en;
  logic [N_CH-1:0]   periodic;
  logic [N_CH-1:0]   ie;
  logic [N_CH-1:0]   armed;
  logic [N_CH-1:0]   pending;
  logic [PTR_W-1:0]  ptr;
  logic [31:0]       shadow;

  logic              wr_en;
  logic              rd_en;
  logic              in_chan;
  logic [CH_W-1:0]   sel_ch;
  logic [1:0]        fld;
  logic [N_CH-1:0]   ch_wr;
  logic [N_CH-1:0]   w1c_mask;
  logic [DATA_W-1:0] rd_mux;

  logic [63:0]       cmp_cur;
  logic              en_cur;
  logic              armed_cur;
  logic              hit;
  logic [N_CH-1:0]   fire;

  // Wrapping 64-bit advance of a periodic compare value.
  function automatic logic [63:0] add_period(input logic [63:0] base,
                                             input logic [31:0] step);
    return base + {32'b0, step};
  endfunction

  assign wr_en   = bus.valid && (|bus.wstrb);
  assign rd_en   = bus.valid && !(|bus.wstrb);
  assign in_chan = (bus.address < A_STATUS);
  assign sel_ch  = bus.address[ADDR_W-1:2];
  assign fld     = bus.address[1:0];

  always_comb begin
    ch_wr    = '0;
    w1c_mask = '0;
    for (int n = 0; n < N_CH; n++) begin
      ch_wr[n] = wr_en && in_chan && (sel_ch == CH_W'(n));
    end
    if (wr_en && (bus.address == A_STATUS)) begin
      w1c_mask = bus.wdata[N_CH-1:0];
    end
  end

  // Read mux; channels at or above N_CH and unmapped words read as zero.
  always_comb begin
    rd_mux = '0;
    if (in_chan) begin
      for (int n = 0; n < N_CH; n++) begin
        if (sel_ch == CH_W'(n)) begin
          case (fld)
            2'd0:    rd_mux = cmp[n][31:0];
            2'd1:    rd_mux = cmp[n][63:32];
            2'd2:    rd_mux = period[n];
            default: rd_mux[2:0] = {ie[n], periodic[n], en[n]};
          endcase
        end
      end
    end else if (bus.address == A_STATUS) begin
      rd_mux[N_CH-1:0] = pending;
    end else if (bus.address == A_TIME_LO) begin
      rd_mux = time_in[31:0];
    end else if (bus.address == A_TIME_HI) begin
      rd_mux = shadow;
    end
  end

  // Scanner: select the visited channel, then one shared >= comparison.
  always_comb begin
    cmp_cur   = '0;
    en_cur    = 1'b0;
    armed_cur = 1'b0;
    for (int n = 0; n < N_CH; n++) begin
      if (ptr == PTR_W'(n)) begin
        cmp_cur   = cmp[n];
        en_cur    = en[n];
        armed_cur = armed[n];
      end
    end
    hit  = en_cur && armed_cur && (time_in >= cmp_cur);
    fire = '0;
    for (int n = 0; n < N_CH; n++) begin
      if (ptr == PTR_W'(n)) begin
        fire[n] = hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < N_CH; n++) begin
        cmp[n]    <= '0;
        period[n] <= '0;
      end
      en       <= '0;
      periodic <= '0;
      ie       <= '0;
      armed    <= '0;
      pending  <= '0;
      ptr      <= '0;
      shadow   <= '0;
      irq      <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      ptr       <= (ptr == PTR_W'(N_CH - 1)) ? '0 : ptr + PTR_W'(1);
      bus.ready <= bus.valid;
      bus.rdata <= rd_en ? rd_mux : '0;
      irq       <= |(pending & ie);
      if (rd_en && (bus.address == A_TIME_LO)) begin
        shadow <= time_in[63:32];
      end
      // A fire in the same cycle as a W1C of that bit leaves it set.
      pending <= (pending & ~w1c_mask) | fire;
      for (int n = 0; n < N_CH; n++) begin
        if (fire[n]) begin
          if (periodic[n] && (period[n] != '0)) begin
            cmp[n] <= add_period(cmp[n], period[n]);
          end else begin
            armed[n] <= 1'b0;
          end
        end
        // CPU writes come last so they override the scanner's update.
        if (ch_wr[n]) begin
          case (fld)
            2'd0:    cmp[n][31:0]  <= bus.wdata[31:0];
            2'd1:    cmp[n][63:32] <= bus.wdata[31:0];
            2'd2:    period[n]     <= bus.wdata[31:0];
            default: begin
              en[n]       <= bus.wdata[0];
              periodic[n] <= bus.wdata[1];
              ie[n]       <= bus.wdata[2];
              armed[n]    <= bus.wdata[0];
            end
          endcase
        end
      end
    end
  end

endmodule
